axi_llc_flush_seq: RTL
======================

# axi_llc_flush_seq

RegBus initiator that drives the LLC configuration port to flush a selected set of cache ways. On a single-cycle request it writes the way mask to the flush register, then polls the flushed-status register until every requested way reads back as flushed. It reports done, error or timeout to its requester. It sits between a system controller (core CSR, power manager) and the LLC `conf_req`/`conf_resp` RegBus slave.

## Interface
- `SetAssociativity`, 8: number of LLC ways. Width of the way mask; ≤ 32.
- `FlushAddr`, 32'h0000_0010: RegBus byte address of the flush register.
- `FlushedAddr`, 32'h0000_0018: RegBus byte address of the flushed-status register.
- `PollInterval`, 16: idle cycles between consecutive status reads; ≥ 1.
- `MaxPolls`, 1024: status reads allowed before timeout; ≥ 1.

Ports:
- `clk_i`  in  1  rising-edge clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_req_i`  in  1  start pulse; sampled only in IDLE.
- `flush_ways_i`  in  SetAssociativity  ways to flush; captured with `flush_req_i`.
- `busy_o`  out  1  high from the cycle after acceptance until return to IDLE.
- `done_o`  out  1  one-cycle pulse on successful completion.
- `error_o`  out  1  one-cycle pulse on bus error or timeout.
- `timeout_o`  out  1  qualifies `error_o`: 1 = timeout, 0 = bus error.
- `conf_req_addr_o`  out  32  RegBus address.
- `conf_req_write_o`  out  1  1 = write.
- `conf_req_wdata_o`  out  32  write data.
- `conf_req_wstrb_o`  out  4  byte strobes.
- `conf_req_valid_o`  out  1  request valid.
- `conf_resp_rdata_i`  in  32  read data.
- `conf_resp_error_i`  in  1  slave error.
- `conf_resp_ready_i`  in  1  transfer complete.

## Operation
- States: IDLE, WRITE, READ, WAIT, DONE, ERR.
- IDLE: if `flush_req_i`, capture the mask and clear the poll counter.
  - Mask == 0: go to DONE.
  - Otherwise go to WRITE.
- WRITE: drive addr=`FlushAddr`, write=1, wdata=zero-extended mask, wstrb=4'hF, valid=1.
  - On ready with error=1: go to ERR.
  - On ready with error=0: go to READ.
- READ: drive addr=`FlushedAddr`, write=0, wdata=0, wstrb=4'h0, valid=1.
  - On ready with error=1: go to ERR.
  - On ready with `(rdata[SetAssociativity-1:0] & mask) == mask`: go to DONE.
  - On ready otherwise, poll counter +1:
    - if the counter reaches `MaxPolls`: go to ERR with the timeout flag set;
    - else go to WAIT and load the interval counter with `PollInterval`.
- WAIT: decrement the interval counter; at 0, go to READ.
- DONE: `done_o`=1 for one cycle, then go to IDLE.
- ERR: `error_o`=1 and `timeout_o`=flag for one cycle, then go to IDLE.
- RegBus rules:
  - Addr/write/wdata/wstrb are held stable while valid=1 and ready=0.
  - Valid is never withdrawn before ready.
  - A transfer completes in the cycle valid&&ready.
  - rdata and error are sampled only in that cycle.
- `flush_req_i` outside IDLE is ignored and not queued. `flush_ways_i` changes after capture have no effect.
- Status bits outside the mask are ignored. Bits ≥ `SetAssociativity` of rdata are ignored.
- Poll counter width is `$clog2(MaxPolls+1)`. Interval counter width is `$clog2(PollInterval+1)`. Neither counter wraps.

## Timing
- Reset values: every output is 0. The state is IDLE, and the mask and counters are cleared.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Request sampled in cycle 0 → `busy_o`=1 and `conf_req_valid_o`=1 in cycle 1.
- Back-to-back transfers: READ is entered in the cycle after the WRITE handshake, so valid stays high across the boundary with new addr/write.
- Minimum flush, slave ready same cycle, first read flushed: valid in cycles 1–2, DONE in cycle 3 (`done_o`=1), IDLE and `busy_o`=0 in cycle 4.
- Each unsuccessful poll adds `PollInterval` WAIT cycles plus the READ handshake latency.
- Empty mask: `done_o` in cycle 1, and no bus valid is ever asserted.
- A new request is accepted in the first IDLE cycle after DONE or ERR.
- Reset mid-transfer: valid drops asynchronously, and no done or error pulse is emitted.

## Test plan
- Mask 8'h0F, slave ready=1 immediately, status reads 32'hF → one write (addr 0x10, wdata 0xF, wstrb 0xF) and one read (addr 0x18); `done_o` pulse in cycle 3.
- Mask 8'hFF, ready delayed 3 cycles per transfer, status reads 0x00, 0x7F, 0xFF → exactly 3 reads, 16 WAIT cycles between reads, request fields stable while stalled, single `done_o`.
- Write answered with `conf_resp_error_i`=1 → no read issued; `error_o`=1 and `timeout_o`=0 for one cycle; then IDLE.
- `MaxPolls`=4, status always 0 → exactly 4 reads, then `error_o`=1 and `timeout_o`=1.
- Mask 0 → `done_o` in cycle 1 and `conf_req_valid_o` never high. `flush_req_i` pulsed while busy → no extra transfers, exactly one completion.
- Assert `rst_ni`=0 while valid is high and ready low → all outputs 0 immediately. After release, a new request starts a clean sequence.

Source files
------------

// File: rtl/axi_llc_flush_seq.sv
// ---------------------------------------------------------------------------
// axi_llc_flush_seq
//
// RegBus initiator that flushes a selected set of LLC ways. A single-cycle
// request writes the way mask to the LLC flush register. The block then polls
// the flushed-status register until every requested way reads back as
// flushed, and reports done, bus error or timeout to the requester.
//
// Ports
//   clk_i, rst_ni         rising-edge clock, asynchronous active-low reset
//   flush_req_i           start pulse, sampled only while idle
//   flush_ways_i          way mask, captured together with flush_req_i
//   busy_o                high while a flush sequence is in progress
//   done_o                one-cycle pulse on successful completion
//   error_o / timeout_o   one-cycle error pulse; timeout_o=1 means poll timeout,
//                         timeout_o=0 means the slave answered with an error
//   conf_req_*_o          RegBus request channel towards the LLC config slave
//   conf_resp_*_i         RegBus response channel from the LLC config slave
// ---------------------------------------------------------------------------
module axi_llc_flush_seq #(
  parameter int unsigned SetAssociativity = 8,
  parameter logic [31:0] FlushAddr        = 32'h0000_0010,
  parameter logic [31:0] FlushedAddr      = 32'h0000_0018,
  parameter int unsigned PollInterval     = 16,
  parameter int unsigned MaxPolls         = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_req_i,
  input  logic [SetAssociativity-1:0] flush_ways_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic                        timeout_o,
  output logic [31:0]                 conf_req_addr_o,
  output logic                        conf_req_write_o,
  output logic [31:0]                 conf_req_wdata_o,
  output logic [3:0]                  conf_req_wstrb_o,
  output logic                        conf_req_valid_o,
  input  logic [31:0]                 conf_resp_rdata_i,
  input  logic                        conf_resp_error_i,
  input  logic                        conf_resp_ready_i
);

  localparam int unsigned PollW = $clog2(MaxPolls + 1);
  localparam int unsigned IvalW = $clog2(PollInterval + 1);

  localparam logic [PollW-1:0] MaxPollsVal     = PollW'(MaxPolls);
  localparam logic [IvalW-1:0] PollIntervalVal = IvalW'(PollInterval);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WAIT,
    DONE,
    ERR
  } state_e;

  state_e                      state_q, state_d;
  logic [SetAssociativity-1:0] mask_q, mask_d;
  logic [PollW-1:0]            poll_q, poll_d;
  logic [IvalW-1:0]            ival_q, ival_d;
  logic                        timeout_q, timeout_d;

  // Status bits at or above SetAssociativity are dropped here; bits outside
  // the requested mask are dropped by the AND in the flushed test below.
  logic [SetAssociativity-1:0] status;
  logic                        all_flushed;

  assign status      = conf_resp_rdata_i[SetAssociativity-1:0];
  assign all_flushed = ((status & mask_q) == mask_q);

  // Next-state logic.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    poll_d    = poll_q;
    ival_d    = ival_q;
    timeout_d = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          mask_d    = flush_ways_i;
          poll_d    = '0;
          timeout_d = 1'b0;
          state_d   = (flush_ways_i == '0) ? DONE : WRITE;
        end
      end

      WRITE: begin
        if (conf_resp_ready_i) begin
          state_d = conf_resp_error_i ? ERR : READ;
        end
      end

      READ: begin
        if (conf_resp_ready_i) begin
          if (conf_resp_error_i) begin
            state_d = ERR;
          end else if (all_flushed) begin
            state_d = DONE;
          end else begin
            poll_d = poll_q + 1'b1;
            // The counter stops at MaxPolls, so it can never wrap.
            if (poll_d == MaxPollsVal) begin
              timeout_d = 1'b1;
              state_d   = ERR;
            end else begin
              ival_d  = PollIntervalVal;
              state_d = WAIT;
            end
          end
        end
      end

      WAIT: begin
        // Loaded with PollInterval, so exactly PollInterval idle cycles
        // separate two status reads.
        ival_d = ival_q - 1'b1;
        if (ival_d == '0) begin
          state_d = READ;
        end
      end

      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: asynchronous reset returns the FSM to IDLE at once, which drops
  // conf_req_valid_o mid-transfer and suppresses any done/error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      poll_q    <= '0;
      ival_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      poll_q    <= poll_d;
      ival_q    <= ival_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs are decoded from registered state only, so no input reaches an
  // output combinationally and the request fields stay stable while stalled.
  always_comb begin
    busy_o           = (state_q != IDLE);
    done_o           = (state_q == DONE);
    error_o          = (state_q == ERR);
    timeout_o        = (state_q == ERR) && timeout_q;
    conf_req_addr_o  = '0;
    conf_req_write_o = 1'b0;
    conf_req_wdata_o = '0;
    conf_req_wstrb_o = 4'h0;
    conf_req_valid_o = 1'b0;

    if (state_q == WRITE) begin
      conf_req_addr_o                         = FlushAddr;
      conf_req_write_o                        = 1'b1;
      conf_req_wdata_o[SetAssociativity-1:0]  = mask_q;
      conf_req_wstrb_o                        = 4'hF;
      conf_req_valid_o                        = 1'b1;
    end else if (state_q == READ) begin
      conf_req_addr_o  = FlushedAddr;
      conf_req_valid_o = 1'b1;
    end
  end

endmodule
